// File: rtl/pll_supervisor_pkg.sv
// Shared types and default constants for the PLL supervisor.
package pll_supervisor_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABILIZE  = 2'd1,
        HOLD_RESET = 2'd2,
        RUN        = 2'd3
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES       = 2;
    localparam int unsigned DEF_STABLE_CYCLES     = 1024;
    localparam int unsigned DEF_RESET_HOLD_CYCLES = 16;
    localparam int unsigned DEF_CNT_W             = 8;

    // Width of the shared sequencing counter: clog2 of the longer phase, at least 1.
    function automatic int unsigned seq_cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pll_supervisor_sync_ff.sv
// Multi-stage synchronizer for asynchronous single-bit inputs; resets to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/pll_supervisor.sv
// PLL lock supervisor: sequences the core reset once lock is stable.
// Optional lock-loss statistics are enabled by PLL_SUPERVISOR_LOSS_COUNT_EN.
module pll_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int unsigned STABLE_CYCLES     = DEF_STABLE_CYCLES,
    parameter int unsigned RESET_HOLD_CYCLES = DEF_RESET_HOLD_CYCLES,
    parameter int unsigned CNT_W             = DEF_CNT_W
) (
    input  logic             clock_in,
    input  logic             resetb,
    input  logic             locked,
    input  logic             clear_count,
    output logic             sys_resetb,
    output logic             ready,
    output logic             lock_lost,
    output logic [CNT_W-1:0] lock_loss_count
);

    localparam int unsigned CW = seq_cnt_width(STABLE_CYCLES, RESET_HOLD_CYCLES);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(RESET_HOLD_CYCLES - 1);

    logic          lock_s;
    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          run_q;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clock_in),
        .rst_n (resetb),
        .d     (locked),
        .q     (lock_s)
    );

    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
            run_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            run_q <= (state_next == RUN);
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            WAIT_LOCK: begin
                cnt_next = '0;
                if (lock_s) state_next = STABILIZE;
            end
            STABILIZE: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = HOLD_RESET;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD_RESET: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == HOLD_LAST) begin
                    state_next = RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_next = WAIT_LOCK;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = WAIT_LOCK;
                cnt_next   = '0;
            end
        endcase
    end

    // Same flop feeds both: sys_resetb rises exactly when ready does.
    assign sys_resetb = run_q;
    assign ready      = run_q;

`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
    logic             run_drop;
    logic             lost_q;
    logic [CNT_W-1:0] loss_q;

    assign run_drop = (state == RUN) && !lock_s;

    // A clear coinciding with a drop leaves that drop recorded.
    always_ff @(posedge clock_in or negedge resetb) begin
        if (!resetb) begin
            lost_q <= 1'b0;
            loss_q <= '0;
        end else if (clear_count) begin
            lost_q <= run_drop;
            loss_q <= run_drop ? CNT_W'(1) : '0;
        end else if (run_drop) begin
            lost_q <= 1'b1;
            if (loss_q != '1) loss_q <= loss_q + 1'b1;
        end
    end

    assign lock_lost       = lost_q;
    assign lock_loss_count = loss_q;
`else
    logic unused_clear;
    assign unused_clear    = clear_count;
    assign lock_lost       = 1'b0;
    assign lock_loss_count = '0;
`endif

endmodule

// File: tb/tb_pll_supervisor.sv
// Scoreboard bench for pll_supervisor: a lock-streak reference model feeds a queue
// that a negedge monitor drains against the DUT outputs.
module tb_pll_supervisor;

    localparam int unsigned SS   = 2;
    localparam int unsigned SC   = 8;
    localparam int unsigned HC   = 4;
    localparam int unsigned CW   = 2;
    localparam int unsigned NEED = SC + HC + 1;

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          locked = 1'b0;
    logic          clear_count = 1'b0;
    logic          sys_resetb;
    logic          ready;
    logic          lock_lost;
    logic [CW-1:0] lock_loss_count;

    pll_supervisor #(
        .SYNC_STAGES       (SS),
        .STABLE_CYCLES     (SC),
        .RESET_HOLD_CYCLES (HC),
        .CNT_W             (CW)
    ) dut (
        .clock_in        (clk),
        .resetb          (resetb),
        .locked          (locked),
        .clear_count     (clear_count),
        .sys_resetb      (sys_resetb),
        .ready           (ready),
        .lock_lost       (lock_lost),
        .lock_loss_count (lock_loss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rdy;
        bit          lost;
        int unsigned cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference: ready iff the synchronized lock has been high for NEED consecutive edges.
    bit          sync_m[SS];
    int unsigned streak;
    bit          m_ready;
    bit          m_lost;
    int unsigned m_cnt;

    function automatic void model_reset();
        for (int i = 0; i < SS; i++) sync_m[i] = 1'b0;
        streak  = 0;
        m_ready = 1'b0;
        m_lost  = 1'b0;
        m_cnt   = 0;
    endfunction

    function automatic void model_edge();
        bit ls;
        bit dropped;
        if (!resetb) return;
        ls = sync_m[SS-1];
        for (int i = SS - 1; i > 0; i--) sync_m[i] = sync_m[i-1];
        sync_m[0] = locked;
        if (ls) streak = (streak < 10000) ? streak + 1 : streak;
        else    streak = 0;
        dropped = m_ready && !ls;
`ifdef PLL_SUPERVISOR_LOSS_COUNT_EN
        if (clear_count) begin
            m_cnt  = dropped ? 1 : 0;
            m_lost = dropped;
        end else if (dropped) begin
            m_lost = 1'b1;
            m_cnt  = (m_cnt < 3) ? m_cnt + 1 : 3;
        end
`endif
        m_ready = (streak >= NEED);
    endfunction

    task automatic step(input bit l, input bit c, input bit r);
        exp_t e;
        @(posedge clk);
        model_edge();
        #2;
        locked      = l;
        clear_count = c;
        resetb      = r;
        if (!r) model_reset();
        e.rdy  = m_ready;
        e.lost = m_lost;
        e.cnt  = m_cnt;
        q.push_back(e);
    endtask

    task automatic hold(input bit l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0, 1'b1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            checks += 4;
            if (ready !== e.rdy) begin
                errors++;
                $display("FAIL ready @%0t: got %b expected %b", $time, ready, e.rdy);
            end
            if (sys_resetb !== e.rdy) begin
                errors++;
                $display("FAIL sys_resetb @%0t: got %b expected %b", $time, sys_resetb, e.rdy);
            end
            if (lock_lost !== e.lost) begin
                errors++;
                $display("FAIL lock_lost @%0t: got %b expected %b", $time, lock_lost, e.lost);
            end
            if (lock_loss_count !== CW'(e.cnt)) begin
                errors++;
                $display("FAIL lock_loss_count @%0t: got %0d expected %0d", $time, lock_loss_count, e.cnt);
            end
        end
    end

    initial begin
        int unsigned seg;
        bit          lvl;
        model_reset();
        #1;
        step(0, 0, 0);
        step(0, 0, 0);
        // First lock: RUN expected at edge 15 after the rise.
        hold(1, 20);
        // Loss in RUN, then relock.
        hold(0, 4);
        hold(1, 20);
        // Short glitch during stabilization restarts sequencing.
        hold(0, 4);
        hold(1, 7);
        hold(0, 1);
        hold(1, 20);
        // Four RUN drops saturate the counter, then clear.
        for (int k = 0; k < 4; k++) begin
            hold(0, 3);
            hold(1, 16);
        end
        step(1, 1, 1);
        hold(1, 2);
        // Clear landing on the drop edge.
        hold(0, 2);
        step(0, 1, 1);
        hold(0, 2);
        hold(1, 16);
        // Reset during HOLD_RESET, then during RUN.
        hold(0, 3);
        hold(1, 12);
        step(1, 0, 0);
        step(1, 0, 0);
        hold(1, 16);
        step(1, 0, 0);
        step(1, 0, 0);
        hold(1, 16);
        // Randomized lock activity with sporadic clears and resets.
        lvl = 1'b0;
        for (int s = 0; s < 200; s++) begin
            lvl = ~lvl;
            seg = lvl ? $urandom_range(1, 24) : $urandom_range(1, 4);
            for (int i = 0; i < int'(seg); i++) begin
                step(lvl, ($urandom_range(0, 15) == 0), ($urandom_range(0, 150) != 0));
            end
        end
        hold(1, 2);
        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
